// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Byte-stream program loader (write side of the instruction memory).
//             Accepts a framed image {SYNC_BYTE, N, 4*N data bytes} on a
//             valid/ready byte interface. It packs the data bytes little-endian
//             into 32-bit words and issues one write pulse per word. cpu_hold
//             stays high while a load is in progress.
//  Ports    : clk, reset (async, active-high)
//             in_valid/in_data/in_ready : byte stream in (xfer = valid & ready)
//             we/wa/wd                  : instruction memory write port
//             cpu_hold/done/err         : processor hold and frame status levels
//  Config   : IMEM_LOADER_CHECKSUM_EN - when defined, each frame carries a
//             trailing XOR byte over all data bytes. It is checked after the
//             last word has been written.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic             r_we;
    logic [31:0]      r_wa;
    logic [31:0]      r_wd;
    logic             r_hold;
    logic             r_done;
    logic             r_err;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_n;
    logic [1:0]       r_lane;
    logic [31:0]      r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic w_xfer;
    logic w_is_sync;
    logic w_n_bad;
    logic w_last_word;
    logic w_start;

    // in_ready is registered, so the handshake is judged against the
    // registered copy that the source also sees.
    assign w_xfer      = in_valid & r_in_ready;
    assign w_is_sync   = (in_data == SYNC_BYTE);
    assign w_n_bad     = (in_data == 8'd0) || (32'(in_data) > 32'(DEPTH));
    assign w_last_word = (r_idx == (r_n - C_IDX_ONE));
    // A new frame may only start from a resting state. Inside COUNT/DATA the
    // sync value is ordinary data.
    assign w_start     = w_xfer && w_is_sync &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_xfer) begin
                    w_state_next = w_n_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && (r_lane == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_state_next = w_last_word ? S_CHECK : S_DATA;
`else
                w_state_next = w_last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    w_state_next = (in_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the state being entered, so they
    // line up with r_state without any combinational path to the ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_wa       <= BASE_ADDR;
            r_wd       <= 32'd0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_n        <= '0;
            r_lane     <= 2'd0;
            r_word     <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_in_ready <= (w_state_next != S_WRITE);
            r_we       <= (w_state_next == S_WRITE);
            r_done     <= (w_state_next == S_DONE);
            r_err      <= (w_state_next == S_ERROR);
            // A rejected frame keeps the processor held: a partial image never runs.
            r_hold     <= (w_state_next == S_COUNT) || (w_state_next == S_DATA)  ||
                          (w_state_next == S_WRITE) || (w_state_next == S_CHECK) ||
                          (w_state_next == S_ERROR);

            if (w_start) begin
                r_idx  <= '0;
                r_lane <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum <= 8'd0;
`endif
            end

            if ((r_state == S_COUNT) && w_xfer) begin
                r_n <= IDX_W'(in_data);
            end

            if ((r_state == S_DATA) && w_xfer) begin
                r_word[{r_lane, 3'b000} +: 8] <= in_data;
                r_lane <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum <= r_csum ^ in_data;
`endif
                // The 4th byte goes straight into wd so the word is presented
                // in the same cycle as the we pulse.
                if (r_lane == 2'd3) begin
                    r_wd <= {in_data, r_word[23:0]};
                    r_wa <= BASE_ADDR + (32'(r_idx) << 2);
                end
            end

            if (r_state == S_WRITE) begin
                r_idx <= r_idx + C_IDX_ONE;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign we       = r_we;
    assign wa       = r_wa;
    assign wd       = r_wd;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Directed self-checking bench for imem_loader. Frames are driven
//             through the valid/ready byte port. Write pulses are captured
//             into queues and compared with hand-computed words and addresses.
//             Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the
//             checksum build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_wa[$];
    logic [31:0] q_wd[$];
    logic [7:0]  frame[$];
    logic        mon_en = 1'b0;
    int          ready_bad = 0;

    imem_loader #(
        .DEPTH    (64),
        .BASE_ADDR(32'h0),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Capture writes and watch that in_ready drops only while we is high.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            q_wa.push_back(wa);
            q_wd.push_back(wd);
        end
        if (mon_en && (in_ready !== ~we)) ready_bad++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while ((in_ready !== 1'b1) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input int gap);
        foreach (frame[i]) send_byte(frame[i], gap);
    endtask

    // Appends the trailing XOR byte in the checksum build; no-op otherwise.
    task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < frame.size(); i++) x = x ^ frame[i];
        frame.push_back(x);
`endif
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", we); end
        total++; if (wa !== 32'h0) begin bad++; $display("FAIL rst_wa got=%h exp=0", wa); end
        total++; if (wd !== 32'h0) begin bad++; $display("FAIL rst_wd got=%h exp=0", wd); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b exp=0", cpu_hold); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea = '{32'h0, 32'h4};
        ed = '{32'hE3A0204B, 32'hE04F000F};
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0};
        add_csum();
        send_frame(0);
        settle();
        total++; if (q_wa.size() != 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", q_wa.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= q_wa.size()) begin
                bad++; $display("FAIL basic_write%0d missing", i);
            end else if ((q_wa[i] !== ea[i]) || (q_wd[i] !== ed[i])) begin
                bad++; $display("FAIL basic_write%0d got=%h/%h exp=%h/%h", i, q_wa[i], q_wd[i], ea[i], ed[i]);
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic_hold got=%b exp=0", cpu_hold); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
        total++; if (wd !== 32'hE04F000F) begin bad++; $display("FAIL basic_wd_hold got=%h exp=E04F000F", wd); end
    endtask

    task automatic test_count_err();
        logic [7:0] nv[2];
        nv = '{8'h00, 8'h41};
        for (int k = 0; k < 2; k++) begin
            q_wa.delete(); q_wd.delete();
            frame = '{8'hA5, nv[k]};
            send_frame(0);
            settle();
            total++; if (err !== 1'b1) begin bad++; $display("FAIL cnterr_err n=%h got=%b exp=1", nv[k], err); end
            total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL cnterr_hold n=%h got=%b exp=1", nv[k], cpu_hold); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL cnterr_done n=%h got=%b exp=0", nv[k], done); end
            total++; if (q_wa.size() != 0) begin bad++; $display("FAIL cnterr_nwrites n=%h got=%0d exp=0", nv[k], q_wa.size()); end
        end
        // Non-sync bytes cannot leave ERROR.
        send_byte(8'h4B, 0);
        send_byte(8'h01, 0);
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_gaps();
        apply_reset();
        q_wa.delete(); q_wd.delete();
        ready_bad = 0;
        mon_en = 1'b1;
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0};
        add_csum();
        send_frame(3);
        settle();
        mon_en = 1'b0;
        total++; if (q_wa.size() != 2) begin bad++; $display("FAIL gaps_nwrites got=%0d exp=2", q_wa.size()); end
        total++;
        if ((q_wa.size() < 2) || (q_wa[0] !== 32'h0) || (q_wd[0] !== 32'hE3A0204B) ||
            (q_wa[1] !== 32'h4) || (q_wd[1] !== 32'hE04F000F)) begin
            bad++; $display("FAIL gaps_writes got_n=%0d exp=0:E3A0204B,4:E04F000F", q_wa.size());
        end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL gaps_ready_only_in_write got=%0d exp=0", ready_bad); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL gaps_done got=%b exp=1", done); end
    endtask

    task automatic test_reset_mid();
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20};
        send_frame(0);
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL mid_hold_loading got=%b exp=1", cpu_hold); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ((in_ready !== 1'b0) || (we !== 1'b0) || (wa !== 32'h0) || (wd !== 32'h0) ||
            (cpu_hold !== 1'b0) || (done !== 1'b0) || (err !== 1'b0)) begin
            bad++;
            $display("FAIL mid_async_reset got rdy=%b we=%b wa=%h wd=%h hold=%b done=%b err=%b exp all zero",
                     in_ready, we, wa, wd, cpu_hold, done, err);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (q_wa.size() != 0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", q_wa.size()); end
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0};
        add_csum();
        send_frame(0);
        settle();
        total++;
        if ((q_wa.size() != 2) || (q_wa[0] !== 32'h0) || (q_wd[0] !== 32'hE3A0204B) ||
            (q_wa[1] !== 32'h4) || (q_wd[1] !== 32'hE04F000F)) begin
            bad++; $display("FAIL mid_reload_writes got_n=%0d exp=0:E3A0204B,4:E04F000F", q_wa.size());
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_reload_done got=%b exp=1", done); end
    endtask

    task automatic test_reload();
        q_wa.delete(); q_wd.delete();
        send_byte(8'hA5, 0);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reload_done_drop got=%b exp=0", done); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL reload_hold got=%b exp=1", cpu_hold); end
        frame = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        add_csum();
        frame.delete(0);
        send_frame(0);
        settle();
        total++;
        if ((q_wa.size() != 1) || (q_wa[0] !== 32'h0) || (q_wd[0] !== 32'h44332211)) begin
            bad++; $display("FAIL reload_write got_n=%0d exp=1 write 0:44332211", q_wa.size());
        end
        total++; if ((done !== 1'b1) || (cpu_hold !== 1'b0)) begin bad++; $display("FAIL reload_status got done=%b hold=%b exp done=1 hold=0", done, cpu_hold); end
    endtask

    task automatic test_sync_in_data();
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h5A, 8'hA5};
        add_csum();
        send_frame(0);
        settle();
        total++;
        if ((q_wa.size() != 1) || (q_wd[0] !== 32'hA55AA5A5)) begin
            bad++; $display("FAIL syncdata_write got_n=%0d exp=1 word A55AA5A5", q_wa.size());
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL syncdata_done got=%b exp=1", done); end
    endtask

    task automatic test_full_depth();
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h40};
        for (int i = 0; i < 256; i++) frame.push_back(8'(i));
        add_csum();
        send_frame(0);
        settle();
        total++; if (q_wa.size() != 64) begin bad++; $display("FAIL full_nwrites got=%0d exp=64", q_wa.size()); end
        total++;
        if ((q_wa.size() != 64) || (q_wa[0] !== 32'h0) || (q_wd[0] !== 32'h03020100) ||
            (q_wa[63] !== 32'hFC) || (q_wd[63] !== 32'hFFFEFDFC)) begin
            bad++; $display("FAIL full_first_last got_n=%0d exp 0:03020100 FC:FFFEFDFC", q_wa.size());
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h89};
        send_frame(0);
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_err got=%b exp=1", err); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL csum_hold got=%b exp=1", cpu_hold); end
        total++; if (q_wa.size() != 2) begin bad++; $display("FAIL csum_nwrites got=%0d exp=2", q_wa.size()); end
        q_wa.delete(); q_wd.delete();
        frame = '{8'hA5, 8'h02, 8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h88};
        send_frame(0);
        settle();
        total++; if ((done !== 1'b1) || (err !== 1'b0)) begin bad++; $display("FAIL csum_good got done=%b err=%b exp done=1 err=0", done, err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_count_err();
        test_gaps();
        test_reset_mid();
        test_reload();
        test_sync_in_data();
        test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
